// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding, byte width, and operand-size helpers.
package cmp_pkg;

    localparam int unsigned CMP_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Number of bytes in a WIDTH-bit operand.
    function automatic int unsigned cmp_num_bytes(input int unsigned width);
        return width / CMP_BYTE_W;
    endfunction

    // Width of the byte index counter; never narrower than one bit.
    function automatic int unsigned cmp_idx_w(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// Operand/result handshake bundle for serial_mag_comp.
// master: operand issuer and result consumer; slave: the comparator.
interface serial_mag_comp_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             res_eq;
    logic             res_gt;
    logic             res_lt;

    modport master (
        output in_valid, op_a, op_b, is_signed, out_ready,
        input  in_ready, out_valid, res_eq, res_gt, res_lt
    );

    modport slave (
        input  in_valid, op_a, op_b, is_signed, out_ready,
        output in_ready, out_valid, res_eq, res_gt, res_lt
    );
endinterface

// File: rtl/eight_bit_comp.sv
// Combinational byte comparator stage with EQ/GT chaining from the
// more-significant bytes. Bytes are compared as unsigned values.
module eight_bit_comp
    import cmp_pkg::*;
(
    input  logic [CMP_BYTE_W-1:0] a,
    input  logic [CMP_BYTE_W-1:0] b,
    input  logic                  eq_prev,
    input  logic                  gt_prev,
    output logic                  eq,
    output logic                  gt
);

    // A lower byte only matters while all higher bytes were equal.
    always_comb begin
        eq = eq_prev & (a == b);
        gt = gt_prev | (eq_prev & (a > b));
    end

endmodule

// File: rtl/serial_mag_comp.sv
// Multi-cycle WIDTH-bit magnitude comparator, one byte per cycle, MSB first.
// Optional macro CMP_EARLY_EXIT_EN: finish as soon as a byte differs.
module serial_mag_comp
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    serial_mag_comp_if.slave   bus,
    output logic               busy
);

    localparam int unsigned      NB      = cmp_num_bytes(WIDTH);
    localparam int unsigned      IDX_W   = cmp_idx_w(NB);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NB - 1);

    state_t                          state;
    state_t                          state_next;
    logic [NB-1:0][CMP_BYTE_W-1:0]   a_reg;
    logic [NB-1:0][CMP_BYTE_W-1:0]   b_reg;
    logic                            sgn_reg;
    logic                            eq_acc;
    logic                            gt_acc;
    logic [IDX_W-1:0]                idx;
    logic [CMP_BYTE_W-1:0]           a_byte;
    logic [CMP_BYTE_W-1:0]           b_byte;
    logic                            eq_byte;
    logic                            gt_byte;
    logic                            last_step;

    // Select the current byte; flipping the sign bits of the top byte turns
    // a two's-complement order into an unsigned one.
    always_comb begin
        a_byte = a_reg[idx];
        b_byte = b_reg[idx];
        if (sgn_reg && (idx == IDX_TOP)) begin
            a_byte[CMP_BYTE_W-1] = ~a_byte[CMP_BYTE_W-1];
            b_byte[CMP_BYTE_W-1] = ~b_byte[CMP_BYTE_W-1];
        end
    end

    eight_bit_comp u_byte_comp (
        .a       (a_byte),
        .b       (b_byte),
        .eq_prev (eq_acc),
        .gt_prev (gt_acc),
        .eq      (eq_byte),
        .gt      (gt_byte)
    );

`ifdef CMP_EARLY_EXIT_EN
    // Once a byte differs the outcome is fixed, so stop there.
    assign last_step = (idx == '0) || !eq_byte;
`else
    assign last_step = (idx == '0);
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_step)     state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // Operand capture, accumulator chain and byte index.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sgn_reg <= 1'b0;
            eq_acc  <= 1'b0;
            gt_acc  <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.op_a;
                        b_reg   <= bus.op_b;
                        sgn_reg <= bus.is_signed;
                        eq_acc  <= 1'b1;
                        gt_acc  <= 1'b0;
                        idx     <= IDX_TOP;
                    end
                end
                ST_RUN: begin
                    eq_acc <= eq_byte;
                    gt_acc <= gt_byte;
                    if (idx != '0) begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and result outputs; results read zero outside DONE.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        bus.res_eq    = (state == ST_DONE) &  eq_acc;
        bus.res_gt    = (state == ST_DONE) &  gt_acc;
        bus.res_lt    = (state == ST_DONE) & ~eq_acc & ~gt_acc;
        busy          = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp (WIDTH=32). Expected results and
// latencies come from a behavioural model; define CMP_EARLY_EXIT_EN for
// both bench and RTL to check the early-exit build.
module tb_serial_mag_comp;

    localparam int unsigned WIDTH = 32;
    localparam int          NB    = 4;

    typedef struct {
        logic [2:0] res;   // {eq, gt, lt}
        int         lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    logic busy;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    serial_mag_comp_if #(.WIDTH(WIDTH)) bus ();

    serial_mag_comp #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        int first = NB;
        for (int i = 0; i < NB; i++) begin
            if (a[i*8 +: 8] != b[i*8 +: 8]) first = NB - i;
        end
`ifdef CMP_EARLY_EXIT_EN
        return first;
`else
        return (first > 0) ? NB : NB;
`endif
    endfunction

    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        logic eq, gt;
        eq = (a == b);
        gt = s ? ($signed(a) > $signed(b)) : (a > b);
        e.res = {eq, gt, ~eq & ~gt};
        e.lat = exp_lat(a, b);
        return e;
    endfunction

    // Issue one operand pair, wait for the result, and consume it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [2:0] res, output int lat, output int acc_cyc, output bit to);
        int guard = 0;
        to = 1'b0; lat = 0; res = '0; acc_cyc = 0;
        bus.op_a = a; bus.op_b = b; bus.is_signed = s; bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clock); #1; guard++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0; to = 1'b1; return;
        end
        @(posedge clock); #1;
        acc_cyc = cyc;
        bus.in_valid  = 1'b0;
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
        while (!bus.out_valid && lat < 50) begin
            @(posedge clock); #1; lat++;
        end
        if (!bus.out_valid) begin
            to = 1'b1; return;
        end
        res = {bus.res_eq, bus.res_gt, bus.res_lt};
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.is_signed = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, busy, bus.res_eq, bus.res_gt, bus.res_lt} !== 6'b100000)
            $display("FAIL reset_state: got %b want 100000", {bus.in_ready, bus.out_valid, busy, bus.res_eq, bus.res_gt, bus.res_lt});
        else n_pass++;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'h12345678, 32'h80000000, 32'h80000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF};
        logic [31:0] tb [6] = '{32'h12345679, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000001};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  tr [6] = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b100, 3'b001};
        for (int i = 0; i < 6; i++) begin
            exp_t e, got_e;
            logic [2:0] res;
            int lat, acc;
            bit to;
            e.res = tr[i];
            e.lat = exp_lat(ta[i], tb[i]);
            exp_q.push_back(e);
            run_op(ta[i], tb[i], ts[i], res, lat, acc, to);
            got_e = exp_q.pop_front();
            n_checks++;
            if (to) $display("FAIL directed_%0d_timeout: got no result want result", i);
            else n_pass++;
            n_checks++;
            if (res !== got_e.res) $display("FAIL directed_%0d_result: got %b want %b", i, res, got_e.res);
            else n_pass++;
            n_checks++;
            if (lat !== got_e.lat) $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, got_e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        exp_t e, got_e;
        int guard = 0;
        e = ref_model(32'h00000100, 32'h000000FF, 1'b0);
        exp_q.push_back(e);
        bus.op_a = 32'h00000100; bus.op_b = 32'h000000FF; bus.is_signed = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && guard < 50) begin
            @(posedge clock); #1; guard++;
        end
        got_e = exp_q.pop_front();
        n_checks++;
        if (!bus.out_valid) $display("FAIL bp_timeout: got out_valid=0 want 1");
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = 1'b1;
            bus.op_a      = $urandom;
            bus.op_b      = $urandom;
            bus.is_signed = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            n_checks++;
            if ({bus.out_valid, bus.in_ready, busy, bus.res_eq, bus.res_gt, bus.res_lt} !== {3'b101, got_e.res})
                $display("FAIL bp_hold_%0d: got %b want %b", i,
                         {bus.out_valid, bus.in_ready, busy, bus.res_eq, bus.res_gt, bus.res_lt}, {3'b101, got_e.res});
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, busy, bus.res_eq, bus.res_gt, bus.res_lt} !== 6'b010000)
            $display("FAIL bp_release: got %b want 010000",
                     {bus.out_valid, bus.in_ready, busy, bus.res_eq, bus.res_gt, bus.res_lt});
        else n_pass++;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL bp_no_capture: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        exp_t e, got_e;
        logic [2:0] res;
        int lat, acc;
        bit to;
        bit seen = 1'b0;
        bus.op_a = 32'h11; bus.op_b = 32'h22; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, busy, bus.res_eq, bus.res_gt, bus.res_lt} !== 6'b100000)
            $display("FAIL midrun_reset: got %b want 100000",
                     {bus.in_ready, bus.out_valid, busy, bus.res_eq, bus.res_gt, bus.res_lt});
        else n_pass++;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL midrun_no_result: got out_valid=1 want 0");
        else n_pass++;
        e = ref_model(32'd5, 32'd3, 1'b0);
        exp_q.push_back(e);
        run_op(32'd5, 32'd3, 1'b0, res, lat, acc, to);
        got_e = exp_q.pop_front();
        n_checks++;
        if (to || res !== 3'b010 || res !== got_e.res)
            $display("FAIL midrun_fresh: got %b (timeout=%0d) want 010", res, to);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [3] = '{32'hCAFEF00D, 32'h00000001, 32'h7FFFFFFF};
        logic [31:0] bb [3] = '{32'hCAFEF00E, 32'h80000000, 32'h7FFFFFFF};
        int prev_acc = 0;
        int prev_lat = 0;
        for (int i = 0; i < 3; i++) begin
            exp_t e, got_e;
            logic [2:0] res;
            int lat, acc;
            bit to;
            e = ref_model(ba[i], bb[i], 1'b1);
            exp_q.push_back(e);
            run_op(ba[i], bb[i], 1'b1, res, lat, acc, to);
            got_e = exp_q.pop_front();
            n_checks++;
            if (to || res !== got_e.res) $display("FAIL b2b_%0d_result: got %b want %b", i, res, got_e.res);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (acc - prev_acc !== prev_lat + 2)
                    $display("FAIL b2b_%0d_spacing: got %0d want %0d", i, acc - prev_acc, prev_lat + 2);
                else n_pass++;
            end
            prev_acc = acc;
            prev_lat = got_e.lat;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            logic [31:0] a, b;
            logic s;
            exp_t e, got_e;
            logic [2:0] res;
            int lat, acc, k;
            bit to;
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: begin
                    b = a;
                    k = $urandom_range(0, 3);
                    b[k*8 +: 8] = 8'($urandom);
                end
                default: b = a ^ (32'h1 << $urandom_range(0, 31));
            endcase
            e = ref_model(a, b, s);
            exp_q.push_back(e);
            run_op(a, b, s, res, lat, acc, to);
            got_e = exp_q.pop_front();
            n_checks++;
            if (to || res !== got_e.res)
                $display("FAIL rand_%0d_result a=%h b=%h s=%0d: got %b want %b", n, a, b, s, res, got_e.res);
            else n_pass++;
            n_checks++;
            if (!$onehot(res)) $display("FAIL rand_%0d_onehot: got %b want one-hot", n, res);
            else n_pass++;
            n_checks++;
            if (lat !== got_e.lat || lat < 1 || lat > NB)
                $display("FAIL rand_%0d_latency a=%h b=%h: got %0d want %0d", n, a, b, lat, got_e.lat);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "simulation time limit");
    end

endmodule
